// File: rtl/lmb_bram_port_arbiter.sv
// lmb_bram_port_arbiter: shares BRAM port B between two LMB-side requesters.
// Optional macro ARB_RR_EN selects round-robin instead of fixed priority.
module lmb_bram_port_arbiter #(
    parameter logic [0:31] C_BASEADDR    = 32'h00000000,
    parameter logic [0:31] C_HIGHADDR    = 32'h0000FFFF,
    parameter int          C_PORT_DWIDTH = 32,
    parameter int          C_NUM_WE      = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Req0,
    input  logic [0:31]              Addr0,
    input  logic [0:C_NUM_WE-1]      We0,
    input  logic [0:C_PORT_DWIDTH-1] Wdata0,
    output logic                     Ack0,
    output logic                     Err0,
    output logic                     Rvalid0,
    output logic [0:C_PORT_DWIDTH-1] Rdata0,
    input  logic                     Req1,
    input  logic [0:31]              Addr1,
    input  logic [0:C_NUM_WE-1]      We1,
    input  logic [0:C_PORT_DWIDTH-1] Wdata1,
    output logic                     Ack1,
    output logic                     Err1,
    output logic                     Rvalid1,
    output logic [0:C_PORT_DWIDTH-1] Rdata1,
    output logic                     BRAM_Rst_B,
    output logic                     BRAM_EN_B,
    output logic [0:C_NUM_WE-1]      BRAM_WEN_B,
    output logic [0:31]              BRAM_Addr_B,
    output logic [0:C_PORT_DWIDTH-1] BRAM_Dout_B,
    input  logic [0:C_PORT_DWIDTH-1] BRAM_Din_B
);

    localparam logic [0:31] C_MASK = C_HIGHADDR - C_BASEADDR;

    logic                     r_ack0, r_ack1;
    logic                     r_err0, r_err1;
    logic                     r_rv0, r_rv1;
    logic                     r_en;
    logic [0:C_NUM_WE-1]      r_wen;
    logic [0:31]              r_addr;
    logic [0:C_PORT_DWIDTH-1] r_dout;
    logic [0:C_PORT_DWIDTH-1] r_rdata0, r_rdata1;
    logic                     r_tag_v, r_tag_o;
    logic                     r_tag2_v, r_tag2_o;

    logic                     w_elig0, w_elig1;
    logic                     w_gnt0, w_gnt1;
    logic                     w_any, w_hit, w_issue, w_rd;
    logic [0:31]              w_addr;
    logic [0:C_NUM_WE-1]      w_we;
    logic [0:C_PORT_DWIDTH-1] w_wdata;

    // A requester in its Ack cycle still shows Req; mask it to avoid a regrant.
    assign w_elig0 = Req0 & ~r_ack0;
    assign w_elig1 = Req1 & ~r_ack1;

`ifdef ARB_RR_EN
    logic r_ptr;

    assign w_gnt0 = w_elig0 & (~w_elig1 | ~r_ptr);
    assign w_gnt1 = w_elig1 & (~w_elig0 | r_ptr);

    // Preference flips to the other requester after every grant.
    always_ff @(posedge Clk) begin
        if (Rst)
            r_ptr <= 1'b0;
        else if (w_gnt0)
            r_ptr <= 1'b1;
        else if (w_gnt1)
            r_ptr <= 1'b0;
    end
`else
    assign w_gnt0 = w_elig0;
    assign w_gnt1 = w_elig1 & ~w_elig0;
`endif

    assign w_any   = w_gnt0 | w_gnt1;
    assign w_addr  = w_gnt1 ? Addr1 : Addr0;
    assign w_we    = w_gnt1 ? We1 : We0;
    assign w_wdata = w_gnt1 ? Wdata1 : Wdata0;
    assign w_hit   = (w_addr & ~C_MASK) == C_BASEADDR;
    assign w_issue = w_any & w_hit;
    assign w_rd    = ~|w_we;

    // Acknowledge the winner; flag an error when its address misses the window.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else begin
            r_ack0 <= w_gnt0;
            r_ack1 <= w_gnt1;
            r_err0 <= w_gnt0 & ~w_hit;
            r_err1 <= w_gnt1 & ~w_hit;
        end
    end

    // Drive the BRAM port from registers; address and data hold when idle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_en   <= 1'b0;
            r_wen  <= '0;
            r_addr <= '0;
            r_dout <= '0;
        end else begin
            r_en  <= w_issue;
            r_wen <= w_issue ? w_we : '0;
            if (w_issue) begin
                r_addr <= {w_addr[0:29], 2'b00};
                r_dout <= w_wdata;
            end
        end
    end

    // Track read ownership through the BRAM latency and return data to it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_tag_v  <= 1'b0;
            r_tag_o  <= 1'b0;
            r_tag2_v <= 1'b0;
            r_tag2_o <= 1'b0;
            r_rv0    <= 1'b0;
            r_rv1    <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_tag_v  <= w_issue & w_rd;
            r_tag_o  <= w_gnt1;
            r_tag2_v <= r_tag_v;
            r_tag2_o <= r_tag_o;
            r_rv0    <= r_tag2_v & ~r_tag2_o;
            r_rv1    <= r_tag2_v & r_tag2_o;
            if (r_tag2_v & ~r_tag2_o)
                r_rdata0 <= BRAM_Din_B;
            if (r_tag2_v & r_tag2_o)
                r_rdata1 <= BRAM_Din_B;
        end
    end

    assign Ack0        = r_ack0;
    assign Ack1        = r_ack1;
    assign Err0        = r_err0;
    assign Err1        = r_err1;
    assign Rvalid0     = r_rv0;
    assign Rvalid1     = r_rv1;
    assign Rdata0      = r_rdata0;
    assign Rdata1      = r_rdata1;
    assign BRAM_Rst_B  = 1'b0;
    assign BRAM_EN_B   = r_en;
    assign BRAM_WEN_B  = r_wen;
    assign BRAM_Addr_B = r_addr;
    assign BRAM_Dout_B = r_dout;

endmodule

// File: tb/tb_lmb_bram_port_arbiter.sv
// Directed bench for lmb_bram_port_arbiter with a write-first BRAM model
// on port B; expected values are hand-computed constants.
module tb_lmb_bram_port_arbiter;

    logic        Clk;
    logic        Rst;
    logic        Req0, Req1;
    logic [0:31] Addr0, Addr1;
    logic [0:3]  We0, We1;
    logic [0:31] Wdata0, Wdata1;
    logic        Ack0, Ack1, Err0, Err1, Rvalid0, Rvalid1;
    logic [0:31] Rdata0, Rdata1;
    logic        BRAM_Rst_B, BRAM_EN_B;
    logic [0:3]  BRAM_WEN_B;
    logic [0:31] BRAM_Addr_B, BRAM_Dout_B, BRAM_Din_B;

    int n_chk  = 0;
    int n_fail = 0;

    logic [0:31] mem [0:255];

    lmb_bram_port_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .Req0(Req0), .Addr0(Addr0), .We0(We0), .Wdata0(Wdata0),
        .Ack0(Ack0), .Err0(Err0), .Rvalid0(Rvalid0), .Rdata0(Rdata0),
        .Req1(Req1), .Addr1(Addr1), .We1(We1), .Wdata1(Wdata1),
        .Ack1(Ack1), .Err1(Err1), .Rvalid1(Rvalid1), .Rdata1(Rdata1),
        .BRAM_Rst_B(BRAM_Rst_B), .BRAM_EN_B(BRAM_EN_B),
        .BRAM_WEN_B(BRAM_WEN_B), .BRAM_Addr_B(BRAM_Addr_B),
        .BRAM_Dout_B(BRAM_Dout_B), .BRAM_Din_B(BRAM_Din_B)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [0:31] merge(input logic [0:31] old,
                                          input logic [0:3] wen,
                                          input logic [0:31] d);
        logic [0:31] r;
        r = old;
        for (int l = 0; l < 4; l++)
            if (wen[l]) r[8*l +: 8] = d[8*l +: 8];
        return r;
    endfunction

    // Write-first synchronous BRAM port B
    always @(posedge Clk) begin
        if (BRAM_EN_B) begin
            mem[BRAM_Addr_B[22:29]] <= merge(mem[BRAM_Addr_B[22:29]], BRAM_WEN_B, BRAM_Dout_B);
            BRAM_Din_B <= merge(mem[BRAM_Addr_B[22:29]], BRAM_WEN_B, BRAM_Dout_B);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input bit who, input logic [0:31] a, input logic [0:3] we,
                       input logic [0:31] d, output logic [0:31] o_addr,
                       output logic [0:3] o_wen, output logic o_en, output logic o_err);
        bit got;
        got = 1'b0;
        if (!who) begin
            Req0 = 1'b1; Addr0 = a; We0 = we; Wdata0 = d;
        end else begin
            Req1 = 1'b1; Addr1 = a; We1 = we; Wdata1 = d;
        end
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge Clk);
            if (who ? Ack1 : Ack0) got = 1'b1;
        end
        chk("ack_seen", {31'b0, got}, 32'd1);
        o_addr = BRAM_Addr_B;
        o_wen  = BRAM_WEN_B;
        o_en   = BRAM_EN_B;
        o_err  = who ? Err1 : Err0;
        if (!who) Req0 = 1'b0;
        else      Req1 = 1'b0;
    endtask

    // Called at the Ack negedge of a read: Rvalid must appear two cycles later
    task automatic rv(input bit who, input string tag, input logic [31:0] exp);
        @(negedge Clk);
        chk({tag, "_early"}, {30'b0, Rvalid0, Rvalid1}, 32'd0);
        @(negedge Clk);
        chk({tag, "_rv"}, {30'b0, Rvalid0, Rvalid1}, who ? 32'd1 : 32'd2);
        chk({tag, "_data"}, who ? Rdata1 : Rdata0, exp);
    endtask

    logic [0:31] o_addr;
    logic [0:3]  o_wen;
    logic        o_en, o_err;
    int g, r0, r1, i0, i1, en_cnt;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 | i;
        Rst = 1'b1;
        Req0 = 1'b1; Addr0 = 32'h0; We0 = 4'h0; Wdata0 = 32'h0;
        Req1 = 1'b1; Addr1 = 32'h4; We1 = 4'h0; Wdata1 = 32'h0;

        // Reset with both requesting: every output stays 0
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            chk("rst_ctl", {24'b0, Ack0, Ack1, Err0, Err1, Rvalid0, Rvalid1, BRAM_EN_B, BRAM_Rst_B}, 32'd0);
            chk("rst_bus", BRAM_Addr_B | BRAM_Dout_B | {28'b0, BRAM_WEN_B} | Rdata0 | Rdata1, 32'd0);
        end
        Rst = 1'b0;
        @(negedge Clk);
        chk("rel_ack", {30'b0, Ack0, Ack1}, 32'd2);
        Req0 = 1'b0;
        @(negedge Clk);
        chk("rel_ack1", {30'b0, Ack0, Ack1}, 32'd1);
        Req1 = 1'b0;
        @(negedge Clk);
        chk("rel_rv0", {30'b0, Rvalid0, Rvalid1}, 32'd2);
        chk("rel_rd0", Rdata0, 32'hA5000000);
        @(negedge Clk);
        chk("rel_rv1", {30'b0, Rvalid0, Rvalid1}, 32'd1);
        chk("rel_rd1", Rdata1, 32'hA5000001);

        // Full write then read
        req(1'b0, 32'h00000010, 4'b1111, 32'hDEADBEEF, o_addr, o_wen, o_en, o_err);
        chk("wr_port", {o_en, o_err, o_wen}, 32'b101111);
        chk("wr_addr", o_addr, 32'h10);
        chk("wr_dout", BRAM_Dout_B, 32'hDEADBEEF);
        req(1'b0, 32'h00000010, 4'b0000, 32'h0, o_addr, o_wen, o_en, o_err);
        chk("rd_port", {o_en, o_err, o_wen}, 32'b100000);
        rv(1'b0, "rd_full", 32'hDEADBEEF);

        // Byte-lane write then read
        req(1'b0, 32'h00000010, 4'b0100, 32'h00AA0000, o_addr, o_wen, o_en, o_err);
        chk("bw_wen", {28'b0, o_wen}, 32'b0100);
        req(1'b0, 32'h00000012, 4'b0000, 32'h0, o_addr, o_wen, o_en, o_err);
        chk("br_addr", o_addr, 32'h10);
        rv(1'b0, "rd_byte", 32'hDEAABEEF);

        // Out-of-window access
        req(1'b0, 32'h00010000, 4'b0000, 32'h0, o_addr, o_wen, o_en, o_err);
        chk("oor_err", {30'b0, o_err, o_en}, 32'd2);
        @(negedge Clk);
        chk("oor_en", {30'b0, BRAM_EN_B, Rvalid0}, 32'd0);
        @(negedge Clk);
        chk("oor_rv", {30'b0, Rvalid0, Err0}, 32'd0);
        chk("oor_hold", Rdata0, 32'hDEAABEEF);

        // Requester 1 write and read back
        req(1'b1, 32'h00000200, 4'b1111, 32'h12345678, o_addr, o_wen, o_en, o_err);
        chk("r1_wr", {o_en, o_err, o_wen}, 32'b101111);
        chk("r1_addr", o_addr, 32'h200);
        req(1'b1, 32'h00000200, 4'b0000, 32'h0, o_addr, o_wen, o_en, o_err);
        rv(1'b1, "r1_rd", 32'h12345678);
        chk("r1_hold0", Rdata0, 32'hDEAABEEF);

        // Both requesters streaming 8 reads each
        g = 0; r0 = 0; r1 = 0; i0 = 0; i1 = 0; en_cnt = 0;
        Req0 = 1'b1; Addr0 = 32'h80; We0 = 4'h0;
        Req1 = 1'b1; Addr1 = 32'h100; We1 = 4'h0;
        for (int c = 0; c < 24; c++) begin
            @(negedge Clk);
            if (BRAM_EN_B) en_cnt++;
            if (Ack0) begin
                chk("st_order0", 32'(g % 2), 32'd0);
                g++; i0++;
                if (i0 < 8) Addr0 = 32'h80 + 32'(4 * i0);
                else Req0 = 1'b0;
            end
            if (Ack1) begin
                chk("st_order1", 32'(g % 2), 32'd1);
                g++; i1++;
                if (i1 < 8) Addr1 = 32'h100 + 32'(4 * i1);
                else Req1 = 1'b0;
            end
            if (Rvalid0) begin
                chk("st_rd0", Rdata0, 32'hA5000020 + 32'(r0));
                r0++;
            end
            if (Rvalid1) begin
                chk("st_rd1", Rdata1, 32'hA5000040 + 32'(r1));
                r1++;
            end
        end
        chk("st_grants", 32'(g), 32'd16);
        chk("st_en", 32'(en_cnt), 32'd16);
        chk("st_rv", 32'(r0 * 16 + r1), 32'd136);
        Req0 = 1'b0; Req1 = 1'b0;

        // Reset during the Ack cycle of a read
        req(1'b0, 32'h00000010, 4'b0000, 32'h0, o_addr, o_wen, o_en, o_err);
        Rst = 1'b1;
        @(negedge Clk);
        chk("mr_ctl", {28'b0, Ack0, Rvalid0, BRAM_EN_B, Err0}, 32'd0);
        Rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            chk("mr_norv", {30'b0, Rvalid0, Rvalid1}, 32'd0);
        end
        chk("mr_rdata", Rdata0, 32'd0);
        req(1'b0, 32'h00000010, 4'b0000, 32'h0, o_addr, o_wen, o_en, o_err);
        rv(1'b0, "mr_rd", 32'hDEAABEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
